// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: stability-qualified reader for a scanned 4-digit seven-segment bus
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   seg[6:0]            segment lines {a,b,c,d,e,f,g}, 1 = lit
//   an[3:0]             one-hot digit enable, an[0] = least significant digit, 0 = idle
//   bcd[15:0]           decoded digits, digit k at bcd[4k+3:4k] (F = blank, E = illegal)
//   digit_ok[3:0]       last accepted pattern of digit k was a legal 0-9 code
//   blank[3:0]          last accepted pattern of digit k was all-off
//   frame_valid         one-cycle pulse when an all-legal 4-digit frame completes
//   err                 one-cycle pulse on an accepted illegal pattern or a multi-hot an
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] bcd,
    output logic [3:0]  digit_ok,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    state_t      state_q, state_d;
    logic [10:0] smp_q, prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  ok_q, ok_d, blank_q, blank_d, seen_q, seen_d, seen_n;
    logic        fv_q, fv_d, err_q, err_d;
    logic        accept, changed, multi, legal, blk;
    logic [3:0]  a, val;
    logic [6:0]  s;
    logic [1:0]  k;

    function automatic logic [3:0] dec(input logic [6:0] p);
        case (p)
            7'b1111110: dec = 4'd0;
            7'b0110000: dec = 4'd1;
            7'b1101101: dec = 4'd2;
            7'b1111001: dec = 4'd3;
            7'b0110011: dec = 4'd4;
            7'b1011011: dec = 4'd5;
            7'b1011111: dec = 4'd6;
            7'b1110000: dec = 4'd7;
            7'b1111111: dec = 4'd8;
            7'b1111011: dec = 4'd9;
            default:    dec = 4'hE;
        endcase
    endfunction

    always_comb begin
        a       = smp_q[10:7];
        s       = smp_q[6:0];
        k       = {a[3] | a[2], a[3] | a[1]};
        changed = smp_q != prev_q;
        multi   = (a & (a - 4'd1)) != 4'd0;
        val     = dec(s);
        blk     = s == 7'd0;
        legal   = !blk && val != 4'hE;
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ok_d    = ok_q;
        blank_d = blank_q;
        seen_d  = seen_q;
        seen_n  = seen_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        accept  = 1'b0;
        if (a == 4'd0) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else if (multi) begin
            // Report a multi-hot enable once, when it first appears
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            seen_d  = 4'd0;
            err_d   = changed;
        end else if (changed) begin
            state_d = S_COUNT;
            cnt_d   = 8'd1;
            accept  = cnt_d == STABLE;
        end else if (state_q == S_COUNT) begin
            cnt_d  = cnt_q + 8'd1;
            accept = cnt_d == STABLE;
        end
        if (accept) begin
            state_d          = S_HOLD;
            bcd_d[4*k +: 4]  = blk ? 4'hF : val;
            ok_d[k]          = legal;
            blank_d[k]       = blk;
            err_d            = !legal && !blk;
            seen_n           = seen_q | (4'd1 << k);
            seen_d           = seen_n == 4'hF ? 4'd0 : seen_n;
            fv_d             = seen_n == 4'hF && ok_d == 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            smp_q   <= 11'd0;
            prev_q  <= 11'd0;
            cnt_q   <= 8'd0;
            bcd_q   <= 16'hFFFF;
            ok_q    <= 4'h0;
            blank_q <= 4'hF;
            seen_q  <= 4'h0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= {an, seg};
            prev_q  <= smp_q;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ok_q    <= ok_d;
            blank_q <= blank_d;
            seen_q  <= seen_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign bcd         = bcd_q;
    assign digit_ok    = ok_q;
    assign blank       = blank_q;
    assign frame_valid = fv_q;
    assign err         = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'd0;
    logic [3:0]  an = 4'd0;
    logic [15:0] bcd;
    logic [3:0]  digit_ok, blank;
    logic        frame_valid, err;

    int tests = 0, fails = 0;
    int err_cnt = 0, fv_cnt = 0, fv_at = 0;

    localparam logic [6:0] D0 = 7'b1111110, D1 = 7'b0110000, D2 = 7'b1101101,
                           D3 = 7'b1111001, D4 = 7'b0110011, D5 = 7'b1011011,
                           D6 = 7'b1011111, D7 = 7'b1110000, D8 = 7'b1111111,
                           D9 = 7'b1111011;

    seg_scan_decoder dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an), .bcd(bcd),
        .digit_ok(digit_ok), .blank(blank), .frame_valid(frame_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (err) err_cnt++;
        if (frame_valid) begin
            fv_cnt++;
            fv_at = fv_at + 0;
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (frame_valid) fv_at = i;
        end
    endtask

    task automatic clr();
        err_cnt = 0;
        fv_cnt  = 0;
        fv_at   = 0;
    endtask

    initial begin
        @(negedge clk);
        // Reset with random inputs
        rst = 1'b1;
        clr();
        hold(4'($urandom), 7'($urandom), 2);
        chk("rst_bcd", 32'(bcd), 32'hFFFF);
        chk("rst_ok", 32'(digit_ok), 32'h0);
        chk("rst_blank", 32'(blank), 32'hF);
        chk("rst_pulses", 32'(err_cnt + fv_cnt), 32'd0);
        rst = 1'b0;
        hold(4'd0, 7'd0, 2);

        // Clean scan of 1234
        clr();
        hold(4'b0001, D4, 6);
        hold(4'b0010, D3, 6);
        hold(4'b0100, D2, 6);
        fv_at = 0;
        hold(4'b1000, D1, 6);
        chk("scan_bcd", 32'(bcd), 32'h1234);
        chk("scan_ok", 32'(digit_ok), 32'hF);
        chk("scan_blank", 32'(blank), 32'h0);
        chk("scan_fv_cnt", 32'(fv_cnt), 32'd1);
        chk("scan_fv_at", 32'(fv_at), 32'd5);
        chk("scan_err", 32'(err_cnt), 32'd0);

        // Glitch rejection and acceptance latency
        clr();
        hold(4'b0001, D0, 3);
        chk("glitch_hold", 32'(bcd[3:0]), 32'h4);
        an  = 4'b0001;
        seg = D1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("glitch_t%0d", i), 32'(bcd[3:0]), i < 5 ? 32'h4 : 32'h1);
        end
        chk("glitch_err", 32'(err_cnt), 32'd0);

        // Illegal pattern inside a full scan
        clr();
        hold(4'b0001, D5, 6);
        hold(4'b0010, D6, 6);
        hold(4'b0100, 7'b1000001, 6);
        hold(4'b1000, D7, 6);
        chk("ill_bcd", 32'(bcd), 32'h7E65);
        chk("ill_ok", 32'(digit_ok), 32'hB);
        chk("ill_err", 32'(err_cnt), 32'd1);
        chk("ill_fv", 32'(fv_cnt), 32'd0);

        // Multi-hot enable clears seen: a later half-scan must not complete a frame
        clr();
        hold(4'b0001, D0, 6);
        hold(4'b0010, D9, 6);
        hold(4'b0011, D8, 3);
        chk("mh_err", 32'(err_cnt), 32'd1);
        chk("mh_bcd", 32'(bcd), 32'h7E90);
        clr();
        hold(4'b0100, D8, 6);
        hold(4'b1000, D3, 6);
        chk("mh_bcd2", 32'(bcd), 32'h3890);
        chk("mh_ok", 32'(digit_ok), 32'hF);
        chk("mh_fv", 32'(fv_cnt), 32'd0);

        // Blank digit
        clr();
        hold(4'b1000, 7'd0, 6);
        chk("blank_bcd", 32'(bcd), 32'hF890);
        chk("blank_ok", 32'(digit_ok), 32'h7);
        chk("blank_blank", 32'(blank), 32'h8);
        chk("blank_err", 32'(err_cnt), 32'd0);

        // Reset mid-count
        hold(4'd0, 7'd0, 2);
        clr();
        hold(4'b0001, D2, 2);
        rst = 1'b1;
        hold(4'b0001, D2, 2);
        chk("mrst_bcd", 32'(bcd), 32'hFFFF);
        chk("mrst_pulses", 32'(err_cnt + fv_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("mrst_t%0d", i), 32'(bcd), i < 5 ? 32'hFFFF : 32'hFFF2);
        end
        chk("mrst_ok", 32'(digit_ok), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
